// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, decoder state and event record for the PS/2 scancode decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } ps2_state_e;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
        logic [7:0] ascii;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO; a push while full is taken only when a pop frees a slot the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          wr_en, rd_en;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (rd_en) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: set-2 make/break/E0 assembly, modifier tracking and event FIFO.
// Define PS2_DEC_ASCII_EN to add ASCII translation and Caps Lock tracking.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_code,
    output logic [7:0]       out_ascii,
    output logic             out_break,
    output logic             out_ext,
    output logic             overflow,
    output logic [CNT_W-1:0] press_count,
    output logic             shift_held,
    output logic             caps_on
);

    ps2_state_e       state_q;
    logic             shift_q, ovf_q;
    logic [7:0]       last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             byte_ok, is_pfx, emit, ev_brk, ev_ext, pop, full, empty;

    assign byte_ok = in_valid && !in_err;
    assign is_pfx  = in_data == PS2_EXT || in_data == PS2_BRK;
    // Every non-prefix byte completes an event; the state only says which kind.
    assign emit    = byte_ok && !is_pfx;
    assign ev_brk  = state_q == ST_F0 || state_q == ST_E0F0;
    assign ev_ext  = state_q == ST_E0 || state_q == ST_E0F0;
    assign pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            shift_q <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            if (in_valid && in_err) state_q <= ST_IDLE;
            else if (in_valid)
                case (state_q)
                    ST_IDLE: state_q <= in_data == PS2_EXT ? ST_E0 : in_data == PS2_BRK ? ST_F0 : ST_IDLE;
                    ST_E0:   state_q <= in_data == PS2_BRK ? ST_E0F0 : in_data == PS2_EXT ? ST_E0 : ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            if (emit && !ev_brk && in_data != last_q) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                last_q <= in_data;
            end
            if (emit && ev_brk && in_data == last_q) last_q <= 8'h00;
            if (emit && !ev_ext && (in_data == PS2_LSHIFT || in_data == PS2_RSHIFT)) shift_q <= !ev_brk;
            if (emit && full && !pop) ovf_q <= 1'b1;
        end
    end

`ifdef PS2_DEC_ASCII_EN
    localparam int EW = $bits(ps2_event_t);

    logic       caps_q;
    ps2_event_t ev;

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic shift, input logic caps);
        logic [7:0] lo, dig, sym;
        lo  = 8'h00;
        dig = 8'h00;
        sym = 8'h00;
        case (code)
            8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
            8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
            8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
            8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
            8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
            8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
            8'h35: lo = "y";  8'h1A: lo = "z";
            8'h16: begin dig = "1"; sym = "!"; end
            8'h1E: begin dig = "2"; sym = "@"; end
            8'h26: begin dig = "3"; sym = "#"; end
            8'h25: begin dig = "4"; sym = "$"; end
            8'h2E: begin dig = "5"; sym = "%"; end
            8'h36: begin dig = "6"; sym = "^"; end
            8'h3D: begin dig = "7"; sym = "&"; end
            8'h3E: begin dig = "8"; sym = "*"; end
            8'h46: begin dig = "9"; sym = "("; end
            8'h45: begin dig = "0"; sym = ")"; end
            default: ;
        endcase
        return lo != 8'h00 ? ((shift ^ caps) ? lo - 8'h20 : lo) :
               dig != 8'h00 ? (shift ? sym : dig) :
               code == 8'h29 ? 8'h20 : code == 8'h5A ? 8'h0D : code == 8'h66 ? 8'h08 : 8'h00;
    endfunction

    // Translation sees the modifier state from before this byte's own update.
    assign ev = '{brk: ev_brk, ext: ev_ext, code: in_data,
                  ascii: ev_ext ? 8'h00 : ascii_of(in_data, shift_q, caps_q)};

    always_ff @(posedge clk) begin
        if (!resetn) caps_q <= 1'b0;
        else if (emit && !ev_ext && !ev_brk && in_data == PS2_CAPS && last_q != PS2_CAPS) caps_q <= !caps_q;
    end

    logic [EW-1:0] fifo_in, fifo_out;
    assign fifo_in = ev;
    assign {out_break, out_ext, out_code, out_ascii} = fifo_out;
    assign caps_on = caps_q;
`else
    localparam int EW = 10;

    logic [EW-1:0] fifo_in, fifo_out;
    assign fifo_in = {ev_brk, ev_ext, in_data};
    assign {out_break, out_ext, out_code} = fifo_out;
    assign out_ascii = 8'h00;
    assign caps_on   = 1'b0;
`endif

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (emit),
        .data_i  (fifo_in),
        .pop_i   (pop),
        .data_o  (fifo_out),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_valid   = !empty;
    assign overflow    = ovf_q;
    assign press_count = cnt_q;
    assign shift_held  = shift_q;

endmodule
